// File: rtl/seq_mult_taint_param_if.sv
// Handshake and data bundle for the taint-tracking sequential multiplier.
// Every data signal travels with a same-width taint companion (_t).
interface seq_mult_taint_param_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               start_t;
  logic               signed_mode;
  logic               signed_mode_t;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplicand_t;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   multiplier_t;
  logic               busy;
  logic               busy_t;
  logic               done;
  logic               done_t;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_t;

  modport master (
    output start, start_t, signed_mode, signed_mode_t,
    output multiplicand, multiplicand_t,
    output multiplier, multiplier_t,
    input  busy, busy_t, done, done_t,
    input  product, product_t
  );

  modport slave (
    input  start, start_t, signed_mode, signed_mode_t,
    input  multiplicand, multiplicand_t,
    input  multiplier, multiplier_t,
    output busy, busy_t, done, done_t,
    output product, product_t
  );
endinterface

// File: rtl/seq_mult_taint_param.sv
// Shift-add sequential multiplier with conservative bit-level taint tracking.
// Fixed latency: WIDTH RUN cycles plus one FIN cycle, done in the cycle after.
module seq_mult_taint_param #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_mult_taint_param_if.slave   bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [W2:0] ONE = (W2+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Sets every bit at or above the lowest set bit.
  function automatic logic [W2:0] smear(input logic [W2:0] x);
    logic [W2:0] low;
    low = x & (-x);
    smear = (x == '0) ? '0 : ~(low - ONE);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [WIDTH-1:0] md_t_q, md_t_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [WIDTH-1:0] mr_t_q, mr_t_d;
  logic [W2:0]      acc_q, acc_d;
  logic [W2:0]      acc_t_q, acc_t_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             sgn_t_q, sgn_t_d;
  logic             sm_t_q, sm_t_d;
  logic             st_t_q, st_t_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [W2-1:0]    prod_t_q, prod_t_d;
  logic             done_q, done_d;
  logic             done_t_q, done_t_d;

  logic [WIDTH:0]   fld;
  logic [WIDTH:0]   fld_t;
  logic [W2:0]      sum;
  logic [W2:0]      sum_t;
  logic [W2:0]      sm_tmp;
  logic [W2-1:0]    pt;
  logic             sa;
  logic             sb;

  always_comb begin
    state_d  = state_q;
    md_d     = md_q;
    md_t_d   = md_t_q;
    mr_d     = mr_q;
    mr_t_d   = mr_t_q;
    acc_d    = acc_q;
    acc_t_d  = acc_t_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sgn_t_d  = sgn_t_q;
    sm_t_d   = sm_t_q;
    st_t_d   = st_t_q;
    prod_d   = prod_q;
    prod_t_d = prod_t_q;
    done_d   = 1'b0;
    done_t_d = 1'b0;
    fld      = '0;
    fld_t    = '0;
    sum      = '0;
    sum_t    = '0;
    sm_tmp   = '0;
    pt       = '0;
    sa       = 1'b0;
    sb       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa      = bus.signed_mode & bus.multiplicand[WIDTH-1];
          sb      = bus.signed_mode & bus.multiplier[WIDTH-1];
          md_d    = sa ? -bus.multiplicand : bus.multiplicand;
          mr_d    = sb ? -bus.multiplier : bus.multiplier;
          neg_d   = sa ^ sb;
          sgn_t_d = bus.signed_mode &
                    (bus.multiplicand_t[WIDTH-1] |
                     bus.multiplier_t[WIDTH-1]);
          md_t_d  = bus.multiplicand_t;
          mr_t_d  = bus.multiplier_t;
          if (bus.signed_mode) begin
            sm_tmp = smear((W2+1)'(bus.multiplicand_t));
            md_t_d = bus.multiplicand_t[WIDTH-1] ? '1
                                                 : sm_tmp[WIDTH-1:0];
            sm_tmp = smear((W2+1)'(bus.multiplier_t));
            mr_t_d = bus.multiplier_t[WIDTH-1] ? '1
                                               : sm_tmp[WIDTH-1:0];
          end
          sm_t_d  = bus.signed_mode_t;
          st_t_d  = bus.start_t;
          acc_d   = '0;
          acc_t_d = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        fld   = acc_q[W2:WIDTH];
        fld_t = acc_t_q[W2:WIDTH];
        if (mr_q[0]) begin
          fld    = fld + {1'b0, md_q};
          sm_tmp = smear((W2+1)'(fld_t | {1'b0, md_t_q}));
          fld_t  = sm_tmp[WIDTH:0];
        end
        // A tainted multiplier bit means the add itself may or may not occur.
        if (mr_t_q[0]) fld_t = '1;
        sum     = {fld, acc_q[WIDTH-1:0]};
        sum_t   = {fld_t, acc_t_q[WIDTH-1:0]};
        acc_d   = sum >> 1;
        acc_t_d = sum_t >> 1;
        mr_d    = mr_q >> 1;
        mr_t_d  = mr_t_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      end

      FIN: begin
        prod_d = neg_q ? -acc_q[W2-1:0] : acc_q[W2-1:0];
        pt     = acc_t_q[W2-1:0];
        if (neg_q) begin
          sm_tmp = smear({1'b0, pt});
          pt     = sm_tmp[W2-1:0];
        end
        if (sgn_t_q | sm_t_q | st_t_q) pt = '1;
        prod_t_d = pt;
        done_d   = 1'b1;
        done_t_d = st_t_q;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      md_q     <= '0;
      md_t_q   <= '0;
      mr_q     <= '0;
      mr_t_q   <= '0;
      acc_q    <= '0;
      acc_t_q  <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sgn_t_q  <= 1'b0;
      sm_t_q   <= 1'b0;
      st_t_q   <= 1'b0;
      prod_q   <= '0;
      prod_t_q <= '0;
      done_q   <= 1'b0;
      done_t_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_q     <= md_d;
      md_t_q   <= md_t_d;
      mr_q     <= mr_d;
      mr_t_q   <= mr_t_d;
      acc_q    <= acc_d;
      acc_t_q  <= acc_t_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sgn_t_q  <= sgn_t_d;
      sm_t_q   <= sm_t_d;
      st_t_q   <= st_t_d;
      prod_q   <= prod_d;
      prod_t_q <= prod_t_d;
      done_q   <= done_d;
      done_t_q <= done_t_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.busy_t    = (state_q != IDLE) & st_t_q;
  assign bus.done      = done_q;
  assign bus.done_t    = done_t_q;
  assign bus.product   = prod_q;
  assign bus.product_t = prod_t_q;

endmodule

// File: tb/tb_seq_mult_taint_param.sv
// Directed vector table for WIDTH=4 plus a WIDTH=8 random regression
// with a flip-one-tainted-bit coverage check on product_t.
module tb_seq_mult_taint_param;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_mult_taint_param_if #(.WIDTH(4)) bus4 ();
  seq_mult_taint_param_if #(.WIDTH(8)) bus8 ();

  seq_mult_taint_param #(.WIDTH(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  seq_mult_taint_param #(.WIDTH(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       sm;
    logic       smt;
    logic [3:0] md;
    logic [3:0] mdt;
    logic [3:0] mr;
    logic [3:0] mrt;
    logic [7:0] ep;
    logic [7:0] ept;
    logic       edt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of RUN cycle 1.
  task automatic issue(input vec_t v);
    bus4.start          = 1'b1;
    bus4.start_t        = v.st;
    bus4.signed_mode    = v.sm;
    bus4.signed_mode_t  = v.smt;
    bus4.multiplicand   = v.md;
    bus4.multiplicand_t = v.mdt;
    bus4.multiplier     = v.mr;
    bus4.multiplier_t   = v.mrt;
    @(posedge clk);
    @(negedge clk);
    bus4.start   = 1'b0;
    bus4.start_t = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!bus4.done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic vec_t mk(input logic st, input logic sm,
      input logic smt, input logic [3:0] md, input logic [3:0] mdt,
      input logic [3:0] mr, input logic [3:0] mrt,
      input logic [7:0] ep, input logic [7:0] ept, input logic edt);
    vec_t v;
    v.st = st; v.sm = sm; v.smt = smt;
    v.md = md; v.mdt = mdt; v.mr = mr; v.mrt = mrt;
    v.ep = ep; v.ept = ept; v.edt = edt;
    return v;
  endfunction

  function automatic logic [15:0] ref8(input logic sm,
      input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] x;
    logic signed [15:0] y;
    x = sm ? 16'($signed(a)) : {8'h00, a};
    y = sm ? 16'($signed(b)) : {8'h00, b};
    return x * y;
  endfunction

  initial begin
    int   n;
    int   seen;
    vec_t v;
    checks = 0;
    errors = 0;
    bus4.start = 0; bus4.start_t = 0;
    bus4.signed_mode = 0; bus4.signed_mode_t = 0;
    bus4.multiplicand = 0; bus4.multiplicand_t = 0;
    bus4.multiplier = 0; bus4.multiplier_t = 0;
    bus8.start = 0; bus8.start_t = 0;
    bus8.signed_mode = 0; bus8.signed_mode_t = 0;
    bus8.multiplicand = 0; bus8.multiplicand_t = 0;
    bus8.multiplier = 0; bus8.multiplier_t = 0;

    //            st sm smt md    mdt   mr    mrt   ep     ept    edt
    tbl[0] = mk(0, 0, 0, 4'h3, 4'h0, 4'h5, 4'h0, 8'h0F, 8'h00, 0);
    tbl[1] = mk(0, 0, 0, 4'hF, 4'h0, 4'hF, 4'h0, 8'hE1, 8'h00, 0);
    tbl[2] = mk(0, 1, 0, 4'hD, 4'h0, 4'h5, 4'h0, 8'hF1, 8'h00, 0);
    tbl[3] = mk(0, 1, 0, 4'h8, 4'h0, 4'h8, 4'h0, 8'h40, 8'h00, 0);
    tbl[4] = mk(0, 0, 0, 4'h3, 4'h1, 4'h1, 4'h0, 8'h03, 8'h1F, 0);
    tbl[5] = mk(0, 0, 0, 4'h2, 4'h0, 4'h1, 4'h8, 8'h02, 8'hF8, 0);
    tbl[6] = mk(1, 0, 0, 4'h3, 4'h0, 4'h5, 4'h0, 8'h0F, 8'hFF, 1);
    tbl[7] = mk(0, 0, 1, 4'h2, 4'h0, 4'h3, 4'h0, 8'h06, 8'hFF, 0);
    tbl[8] = mk(0, 1, 0, 4'hD, 4'h8, 4'h5, 4'h0, 8'hF1, 8'hFF, 0);
    tbl[9] = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus4.busy}, 0);
    chk("rst_done", {31'd0, bus4.done}, 0);
    chk("rst_prod", {24'd0, bus4.product}, 0);
    chk("rst_taint", {28'd0, bus4.busy_t, bus4.done_t,
                      |bus4.product_t, |bus8.product_t}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      issue(tbl[i]);
      chk($sformatf("v%0d_busy", i), {31'd0, bus4.busy}, 1);
      chk($sformatf("v%0d_busy_t", i), {31'd0, bus4.busy_t},
          {31'd0, tbl[i].st});
      wait_done(1, n);
      chk($sformatf("v%0d_lat", i), n, 6);
      chk($sformatf("v%0d_prod", i), {24'd0, bus4.product},
          {24'd0, tbl[i].ep});
      chk($sformatf("v%0d_prod_t", i), {24'd0, bus4.product_t},
          {24'd0, tbl[i].ept});
      chk($sformatf("v%0d_done_t", i), {31'd0, bus4.done_t},
          {31'd0, tbl[i].edt});
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {31'd0, bus4.done}, 0);
      chk($sformatf("v%0d_hold", i), {24'd0, bus4.product},
          {24'd0, tbl[i].ep});
    end

    // Start during RUN must be ignored.
    issue(tbl[0]);
    bus4.start = 1'b1; bus4.start_t = 1'b1; bus4.signed_mode = 1'b1;
    bus4.multiplicand = 4'hF; bus4.multiplier = 4'hF;
    @(negedge clk);
    bus4.start = 1'b0; bus4.start_t = 1'b0;
    chk("ign_busy_t", {31'd0, bus4.busy_t}, 0);
    wait_done(2, n);
    chk("ign_lat", n, 6);
    chk("ign_prod", {24'd0, bus4.product}, 32'h0F);
    chk("ign_prod_t", {24'd0, bus4.product_t}, 0);

    // Start in the done cycle is accepted.
    issue(tbl[1]);
    chk("b2b_busy", {31'd0, bus4.busy}, 1);
    wait_done(1, n);
    chk("b2b_lat", n, 6);
    chk("b2b_prod", {24'd0, bus4.product}, 32'hE1);

    // Reset at RUN cycle 2 aborts with no done.
    @(negedge clk);
    issue(tbl[6]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus4.busy}, 0);
    chk("abort_prod", {24'd0, bus4.product}, 0);
    chk("abort_taint", {23'd0, bus4.busy_t, bus4.product_t}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus4.done) seen++;
    end
    chk("abort_no_done", seen, 0);
    issue(tbl[7]);
    wait_done(1, n);
    chk("post_rst_lat", n, 6);
    chk("post_rst_prod", {24'd0, bus4.product}, 32'h06);

    // WIDTH=8 regression.
    for (int i = 0; i < 24; i++) begin
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  at;
      logic [7:0]  bt;
      logic [15:0] p0;
      logic [15:0] p1;
      logic        sm;
      int          k;
      a  = 8'($urandom);
      b  = 8'($urandom);
      sm = 1'($urandom_range(0, 1));
      k  = $urandom_range(0, 15);
      at = '0;
      bt = '0;
      if (i % 4 != 0) begin
        if (k < 8) at[k] = 1'b1;
        else bt[k-8] = 1'b1;
      end
      p0 = ref8(sm, a, b);
      p1 = ref8(sm, a ^ at, b ^ bt);
      @(negedge clk);
      bus8.start = 1'b1; bus8.signed_mode = sm;
      bus8.multiplicand = a; bus8.multiplicand_t = at;
      bus8.multiplier = b; bus8.multiplier_t = bt;
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      n = 1;
      while (!bus8.done && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("w8_%0d_lat", i), n, 10);
      chk($sformatf("w8_%0d_prod", i), {16'd0, bus8.product},
          {16'd0, p0});
      chk($sformatf("w8_%0d_cover", i),
          {16'd0, (p0 ^ p1) & ~bus8.product_t}, 0);
      if (i % 4 == 0)
        chk($sformatf("w8_%0d_clean", i), {16'd0, bus8.product_t}, 0);
      chk($sformatf("w8_%0d_done_t", i), {31'd0, bus8.done_t}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_taint_param.md
SEQ_MULT_TAINT_PARAM -- requirements
Module: seq_mult_taint_param

Interface
REQ-001 Parameter WIDTH, default 8, operand width; legal values 2..32; product width 2*WIDTH.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start, start_t  in  1 each  request to begin an operation, and its taint.
REQ-005 signed_mode, signed_mode_t  in  1 each  1 = two's-complement operands, 0 = unsigned; plus taint.
REQ-006 multiplicand, multiplicand_t  in  WIDTH each  operand A and its per-bit taint.
REQ-007 multiplier, multiplier_t  in  WIDTH each  operand B and its per-bit taint.
REQ-008 busy, busy_t  out  1 each  operation in progress, and its taint.
REQ-009 done, done_t  out  1 each  one-cycle completion pulse, and its taint.
REQ-010 product, product_t  out  2*WIDTH each  registered result and its per-bit taint.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and FIN; busy SHALL be 1 exactly in RUN and FIN.
REQ-012 start SHALL be accepted only in IDLE; in RUN and FIN it SHALL be ignored, with no effect on state, operands or taint.
REQ-013 On acceptance the block SHALL latch both operands, both operand taints, signed_mode, signed_mode_t and start_t; clear the (2*WIDTH+1)-bit accumulator and its taint; set the iteration counter to 0; and enter RUN.
REQ-014 In signed mode, latched operands SHALL be converted to magnitudes.
REQ-015 A negate flag SHALL be latched as the XOR of the operand sign bits; in unsigned mode the negate flag SHALL be 0.
REQ-016 Each RUN cycle SHALL compute acc <= (acc + (mr[0] ? md<<WIDTH : 0)) >> 1 as a logical shift, shift mr right by 1 and increment the counter.
REQ-017 After WIDTH RUN cycles the FSM SHALL enter FIN.
REQ-018 The FIN cycle SHALL write product = acc[2W-1:0], negated mod 2^(2W) if the negate flag is set, and return to IDLE.
REQ-019 done SHALL pulse for the first cycle after FIN; latency from the start-accept edge to done=1 SHALL be exactly WIDTH+2 cycles, independent of data.
REQ-020 product and product_t SHALL hold their values until the next FIN.
REQ-021 Add taint: for each addition, the result taint SHALL be smear-up(a_t | b_t), i.e. every bit at or above the lowest tainted input bit within the field.
REQ-022 If the examined mr_t[0] is 1, the entire added field acc[2W:W] SHALL become tainted that cycle.
REQ-023 Shift taint SHALL move identically to data, with a 0 taint shifted in.
REQ-024 Signed conversion taint: if the sign bit of an operand is tainted, that operand's full magnitude taint SHALL be set; otherwise its taint SHALL be smear-up of its operand taint.
REQ-025 Negation taint: product_t SHALL be all ones if either sign-bit taint is set; otherwise it SHALL be smear-up(acc_t).
REQ-026 If signed_mode_t was latched as 1, product_t SHALL be all ones.
REQ-027 If start_t was latched as 1, product_t SHALL be all ones.
REQ-028 busy_t and done_t SHALL equal latched start_t during the operation; done_t SHALL accompany the done pulse; both SHALL be 0 in IDLE before any tainted start.
REQ-029 Because timing is data-independent, operand taints SHALL NOT affect busy_t or done_t.
REQ-030 A start asserted in the same cycle as the done pulse (FSM in IDLE) SHALL be accepted normally.

Reset
REQ-031 rst_n=0 SHALL force IDLE immediately, regardless of the clock.
REQ-032 During reset, busy=0, done=0, product=0, all taint outputs 0, and accumulator, counter and latched operands cleared.
REQ-033 Reset mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted.

Verification (WIDTH=4 unless noted)
REQ-034 Unsigned: md=3, mr=5, no taint -> done on cycle 6 after accept, product=8'h0F, product_t=0.
REQ-035 Unsigned 15*15 -> product=8'hE1; signed -3*5 (md=4'hD, mr=4'h5) -> product=8'hF1; signed -8*-8 -> product=8'h40.
REQ-036 md=3, md_t=4'b0001, mr=1, mr_t=0 -> product=8'h03, product_t=8'h1F.
REQ-037 md=2, mr=1, mr_t=4'b1000 -> product=8'h02, product_t=8'hF8.
REQ-038 start_t=1 with clean operands -> product_t=8'hFF and done_t=1; then a start during RUN is ignored, and reset asserted at RUN cycle 2 gives busy=0, product=0 with no done pulse.
REQ-039 WIDTH=8 regression: random signed and unsigned operands -> product matches the reference multiply, latency=10, and the taint outputs are a superset of the bits a golden taint model can influence.
